// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite position controller.
// Collision bit map, FSM states and the signed per-axis direction type.
package sprite_pkg;

   localparam int DEF_BG_SIZE_X   = 1000;
   localparam int DEF_BG_SIZE_Y   = 1000;
   localparam int DEF_SPRITE_SIZE = 16;

   localparam int COL_RIGHT  = 0;
   localparam int COL_LEFT   = 1;
   localparam int COL_BOTTOM = 2;
   localparam int COL_TOP    = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      MOVE   = 2'd2
   } state_t;

   typedef logic signed [1:0] dir_t;

   // Opposing buttons cancel out.
   function automatic dir_t req_dir(input logic neg, input logic pos);
      dir_t d;
      d = 2'sd0;
      if (pos && !neg)
         d = 2'sd1;
      else if (neg && !pos)
         d = -2'sd1;
      return d;
   endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// One axis of sprite motion: collision gating, step, clamp to 0..MAX_POS.
// SPRITE_KNOCKBACK_EN: a suppressed step is reversed instead of held.
module sprite_axis_step
   import sprite_pkg::*;
#(
   parameter int MAX_POS = 984,
   parameter int STEP    = 2
) (
   input  logic [9:0] pos,
   input  logic [1:0] dir,
   input  logic       hit_pos,
   input  logic       hit_neg,
   output logic [9:0] pos_next,
   output logic       blocked
);

   localparam logic signed [10:0] STEP_S = 11'(STEP);
   localparam logic signed [10:0] MAX_S  = 11'(MAX_POS);

   dir_t              d;
   dir_t              eff;
   logic signed [10:0] sum;

   assign d = dir;

   always_comb begin
      blocked = (d == 2'sd1 && hit_pos) || (d == -2'sd1 && hit_neg);
      eff     = d;
      if (blocked) begin
`ifdef SPRITE_KNOCKBACK_EN
         eff = -d;
`else
         eff = 2'sd0;
`endif
      end
      sum = $signed({1'b0, pos});
      if (eff == 2'sd1)
         sum = sum + STEP_S;
      else if (eff == -2'sd1)
         sum = sum - STEP_S;
      if (sum[10])
         pos_next = '0;
      else if (sum > MAX_S)
         pos_next = MAX_S[9:0];
      else
         pos_next = sum[9:0];
   end

endmodule

// File: rtl/sprite_mover.sv
// Per-frame sprite position controller: sample buttons/collision, then step.
// Optional SPRITE_KNOCKBACK_EN (see sprite_axis_step) bounces off collided edges.
module sprite_mover
   import sprite_pkg::*;
#(
   parameter int BG_SIZE_X   = DEF_BG_SIZE_X,
   parameter int BG_SIZE_Y   = DEF_BG_SIZE_Y,
   parameter int SPRITE_SIZE = DEF_SPRITE_SIZE,
   parameter int STEP        = 2,
   parameter int START_X     = 492,
   parameter int START_Y     = 492
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic [3:0] collision,
   output logic [9:0] posX_sp,
   output logic [9:0] posY_sp,
   output logic       moving,
   output logic       blocked,
   output logic       overrun
);

   localparam int MAX_X = BG_SIZE_X - SPRITE_SIZE;
   localparam int MAX_Y = BG_SIZE_Y - SPRITE_SIZE;

   state_t     state, state_n;
   logic       tick_q;
   logic       left_q, right_q, up_q, down_q;
   logic [3:0] col_q;
   logic [1:0] dir_x, dir_y;
   logic [9:0] x_n, y_n;
   logic       blk_x, blk_y;

   // Tick is registered first so no input reaches the FSM combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tick_q <= 1'b0;
      else
         tick_q <= frame_tick;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (tick_q) state_n = SAMPLE;
         SAMPLE:  state_n = MOVE;
         MOVE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         left_q  <= 1'b0;
         right_q <= 1'b0;
         up_q    <= 1'b0;
         down_q  <= 1'b0;
         col_q   <= '0;
      end else if (state == SAMPLE) begin
         left_q  <= btn_left;
         right_q <= btn_right;
         up_q    <= btn_up;
         down_q  <= btn_down;
         col_q   <= collision;
      end
   end

   assign dir_x = req_dir(left_q, right_q);
   assign dir_y = req_dir(up_q, down_q);

   sprite_axis_step #(
      .MAX_POS (MAX_X),
      .STEP    (STEP)
   ) u_axis_x (
      .pos      (posX_sp),
      .dir      (dir_x),
      .hit_pos  (col_q[COL_RIGHT]),
      .hit_neg  (col_q[COL_LEFT]),
      .pos_next (x_n),
      .blocked  (blk_x)
   );

   sprite_axis_step #(
      .MAX_POS (MAX_Y),
      .STEP    (STEP)
   ) u_axis_y (
      .pos      (posY_sp),
      .dir      (dir_y),
      .hit_pos  (col_q[COL_BOTTOM]),
      .hit_neg  (col_q[COL_TOP]),
      .pos_next (y_n),
      .blocked  (blk_y)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         posX_sp <= 10'(START_X);
         posY_sp <= 10'(START_Y);
         moving  <= 1'b0;
         blocked <= 1'b0;
         overrun <= 1'b0;
      end else begin
         moving  <= 1'b0;
         blocked <= 1'b0;
         if (tick_q && state != IDLE)
            overrun <= 1'b1;
         if (state == MOVE) begin
            posX_sp <= x_n;
            posY_sp <= y_n;
            moving  <= (x_n != posX_sp) || (y_n != posY_sp);
            blocked <= blk_x | blk_y;
         end
      end
   end

endmodule

// File: tb/tb_sprite_mover.sv
// Self-checking bench for sprite_mover: two instances (centre and corner start)
// driven in lockstep and compared against an arithmetic reference model.
module tb_sprite_mover;

   localparam int STEP = 2;
   localparam int MAXP = 984;
   localparam int A_X0 = 492;
   localparam int A_Y0 = 492;
   localparam int B_X0 = 983;
   localparam int B_Y0 = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic       btn_left, btn_right, btn_up, btn_down;
   logic [3:0] collision;
   logic [9:0] a_x, a_y, b_x, b_y;
   logic       a_mv, a_bk, a_ov, b_mv, b_bk, b_ov;

   int errors = 0;
   int checks = 0;
   int ax, ay, bx, by;
   bit ovr;

   always #5 clk = ~clk;

   sprite_mover dut_a (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .collision  (collision),
      .posX_sp    (a_x),
      .posY_sp    (a_y),
      .moving     (a_mv),
      .blocked    (a_bk),
      .overrun    (a_ov)
   );

   sprite_mover #(
      .START_X (B_X0),
      .START_Y (B_Y0)
   ) dut_b (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .collision  (collision),
      .posX_sp    (b_x),
      .posY_sp    (b_y),
      .moving     (b_mv),
      .blocked    (b_bk),
      .overrun    (b_ov)
   );

   function automatic int clampi(input int v);
      if (v < 0) return 0;
      if (v > MAXP) return MAXP;
      return v;
   endfunction

   // d is -1/0/+1; hit means the edge d is heading into has collided.
   function automatic int ref_axis(input int p, input int d, input bit hit);
      if (hit) begin
`ifdef SPRITE_KNOCKBACK_EN
         return clampi(p - d * STEP);
`else
         return p;
`endif
      end
      return clampi(p + d * STEP);
   endfunction

   task automatic model_reset();
      ax = A_X0; ay = A_Y0; bx = B_X0; by = B_Y0; ovr = 1'b0;
   endtask

   task automatic frame(input bit l, input bit r, input bit u, input bit dn,
                        input logic [3:0] col, input string tag);
      int dx, dy, nax, nay, nbx, nby;
      bit hx, hy, emv_a, emv_b;
      @(negedge clk);
      btn_left = l; btn_right = r; btn_up = u; btn_down = dn;
      collision = col; frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({a_x, a_y, b_x, b_y} !== {10'(ax), 10'(ay), 10'(bx), 10'(by)}) begin
         errors++;
         $display("FAIL %s early: got A(%0d,%0d) B(%0d,%0d) exp A(%0d,%0d) B(%0d,%0d)",
                  tag, a_x, a_y, b_x, b_y, ax, ay, bx, by);
      end
      dx = int'(r) - int'(l);
      dy = int'(dn) - int'(u);
      hx = (dx > 0 && col[0]) || (dx < 0 && col[1]);
      hy = (dy > 0 && col[2]) || (dy < 0 && col[3]);
      nax = ref_axis(ax, dx, hx); nay = ref_axis(ay, dy, hy);
      nbx = ref_axis(bx, dx, hx); nby = ref_axis(by, dy, hy);
      emv_a = (nax != ax) || (nay != ay);
      emv_b = (nbx != bx) || (nby != by);
      ax = nax; ay = nay; bx = nbx; by = nby;
      @(negedge clk);
      checks++;
      if ({a_x, a_y} !== {10'(ax), 10'(ay)}) begin
         errors++;
         $display("FAIL %s posA: got (%0d,%0d) exp (%0d,%0d)", tag, a_x, a_y, ax, ay);
      end
      checks++;
      if ({b_x, b_y} !== {10'(bx), 10'(by)}) begin
         errors++;
         $display("FAIL %s posB: got (%0d,%0d) exp (%0d,%0d)", tag, b_x, b_y, bx, by);
      end
      checks++;
      if ({a_mv, a_bk, a_ov, b_mv, b_bk, b_ov} !==
          {emv_a, hx | hy, ovr, emv_b, hx | hy, ovr}) begin
         errors++;
         $display("FAIL %s flags mv/bk/ov A=%b%b%b B=%b%b%b exp A=%b%b%b B=%b%b%b",
                  tag, a_mv, a_bk, a_ov, b_mv, b_bk, b_ov,
                  emv_a, hx | hy, ovr, emv_b, hx | hy, ovr);
      end
      @(negedge clk);
      checks++;
      if ({a_mv, a_bk, b_mv, b_bk} !== 4'b0000) begin
         errors++;
         $display("FAIL %s pulse: got mv/bk A=%b%b B=%b%b exp 0000",
                  tag, a_mv, a_bk, b_mv, b_bk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; frame_tick = 1'b0; collision = '0;
      btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({a_x, a_y, b_x, b_y, a_mv, a_bk, a_ov, b_mv, b_bk, b_ov} !==
          {10'(A_X0), 10'(A_Y0), 10'(B_X0), 10'(B_Y0), 6'b0}) begin
         errors++;
         $display("FAIL reset: got A(%0d,%0d) B(%0d,%0d) flags %b%b%b%b%b%b",
                  a_x, a_y, b_x, b_y, a_mv, a_bk, a_ov, b_mv, b_bk, b_ov);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_idle();
      frame(0, 0, 0, 0, 4'b0000, "idle");
   endtask

   task automatic test_blocked();
      frame(0, 1, 0, 0, 4'b0001, "block_right");
      frame(1, 0, 0, 0, 4'b0001, "away_right");
      frame(0, 0, 1, 0, 4'b1000, "block_top");
   endtask

   task automatic test_move();
      frame(0, 1, 0, 0, 4'b0000, "right");
      frame(0, 0, 1, 0, 4'b0000, "up1");
      frame(0, 0, 1, 0, 4'b0000, "up2");
      frame(1, 1, 0, 0, 4'b0001, "left_right");
      frame(0, 0, 1, 1, 4'b1000, "up_down");
   endtask

   task automatic test_random();
      logic [3:0] cols [5];
      cols = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      for (int i = 0; i < 24; i++) begin
         frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               cols[$urandom_range(0, 4)], "random");
      end
   endtask

   task automatic test_overrun();
      @(negedge clk);
      btn_left = 0; btn_right = 1; btn_up = 0; btn_down = 1;
      collision = '0; frame_tick = 1'b1;
      @(negedge clk);
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (4) @(negedge clk);
      ax = ref_axis(ax, 1, 0); ay = ref_axis(ay, 1, 0);
      bx = ref_axis(bx, 1, 0); by = ref_axis(by, 1, 0);
      ovr = 1'b1;
      checks++;
      if ({a_x, a_y, b_x, b_y} !== {10'(ax), 10'(ay), 10'(bx), 10'(by)}) begin
         errors++;
         $display("FAIL overrun_pos: got A(%0d,%0d) B(%0d,%0d) exp A(%0d,%0d) B(%0d,%0d)",
                  a_x, a_y, b_x, b_y, ax, ay, bx, by);
      end
      checks++;
      if ({a_ov, b_ov} !== 2'b11) begin
         errors++;
         $display("FAIL overrun_set: got %b%b exp 11", a_ov, b_ov);
      end
      frame(1, 0, 0, 0, 4'b0000, "after_overrun");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      btn_left = 0; btn_right = 1; btn_up = 1; btn_down = 0;
      collision = '0; frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({a_x, a_y, b_x, b_y, a_mv, a_bk, a_ov, b_mv, b_bk, b_ov} !==
          {10'(A_X0), 10'(A_Y0), 10'(B_X0), 10'(B_Y0), 6'b0}) begin
         errors++;
         $display("FAIL reset_async: got A(%0d,%0d) B(%0d,%0d) flags %b%b%b%b%b%b",
                  a_x, a_y, b_x, b_y, a_mv, a_bk, a_ov, b_mv, b_bk, b_ov);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if ({a_x, a_y, b_x, b_y, a_mv, a_ov} !==
          {10'(A_X0), 10'(A_Y0), 10'(B_X0), 10'(B_Y0), 2'b00}) begin
         errors++;
         $display("FAIL reset_discard: got A(%0d,%0d) B(%0d,%0d) mv=%b ov=%b",
                  a_x, a_y, b_x, b_y, a_mv, a_ov);
      end
      frame(0, 0, 0, 0, 4'b0000, "post_reset");
   endtask

   initial begin
      test_reset();
      test_idle();
      test_blocked();
      test_move();
      test_random();
      test_overrun();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
